// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and types for the interrupt pending/arbiter path
package irq_pkg;

    localparam int IRQ_N = 8;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [id_width(IRQ_N)-1:0] irq_id_t;

endpackage

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - combinational highest-index priority encoder
module prio_enc_n #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    output logic [IDW-1:0] idx,
    output logic           any
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - interrupt capture, pending register and registered grant output
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int N   = IRQ_N,
    parameter int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   irq_in,
    input  logic [N-1:0]   edge_sel,
    input  logic [N-1:0]   mask,
    input  logic           id_ready,
    output logic [IDW-1:0] id_out,
    output logic           id_valid,
    output logic [N-1:0]   pending,
    output logic           lost,
    input  logic           lost_clr
);

    logic [N-1:0]   irq_q, irq_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [IDW-1:0] id_out_q, id_out_d;
    logic           id_valid_q, id_valid_d;
    logic           lost_q, lost_d;

    logic           handshake;
    logic [N-1:0]   clr_vec;
    logic [N-1:0]   set_vec;
    logic [N-1:0]   cand;
    logic [IDW-1:0] winner;
    logic           cand_any;

    // Capture and selection front end; the accepted id is removed from
    // candidates so a handshake edge can load the next winner directly.
    always_comb begin
        handshake = id_valid_q & id_ready;
        clr_vec   = '0;
        if (handshake) begin
            clr_vec[id_out_q] = 1'b1;
        end
        set_vec   = (edge_sel & irq_in & ~irq_q) | (~edge_sel & irq_in);
        cand      = pending_q & ~clr_vec & mask;
    end

    prio_enc_n #(
        .N   (N),
        .IDW (IDW)
    ) u_prio_enc (
        .req (cand),
        .idx (winner),
        .any (cand_any)
    );

    always_comb begin
        irq_d     = irq_in;
        pending_d = set_vec | (pending_q & ~clr_vec);
        lost_d    = ~lost_clr & (lost_q | (|(edge_sel & set_vec & pending_q & ~clr_vec)));
        if (id_valid_q && !id_ready) begin
            id_valid_d = id_valid_q;
            id_out_d   = id_out_q;
        end else begin
            id_valid_d = en & cand_any;
            id_out_d   = cand_any ? winner : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q      <= '0;
            pending_q  <= '0;
            id_out_q   <= '0;
            id_valid_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            irq_q      <= irq_d;
            pending_q  <= pending_d;
            id_out_q   <= id_out_d;
            id_valid_q <= id_valid_d;
            lost_q     <= lost_d;
        end
    end

    assign id_out   = id_out_q;
    assign id_valid = id_valid_q;
    assign pending  = pending_q;
    assign lost     = lost_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - randomized and directed self-checking bench for irq_pending_arbiter
module tb_irq_pending_arbiter;

    localparam int N   = 8;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   irq_in;
    logic [N-1:0]   edge_sel;
    logic [N-1:0]   mask;
    logic           id_ready;
    logic [IDW-1:0] id_out;
    logic           id_valid;
    logic [N-1:0]   pending;
    logic           lost;
    logic           lost_clr;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit [N-1:0] m_prev;
    bit [N-1:0] m_pend;
    bit         m_valid;
    int         m_id;
    bit         m_lost;

    always #5 clk = ~clk;

    irq_pending_arbiter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .irq_in   (irq_in),
        .edge_sel (edge_sel),
        .mask     (mask),
        .id_ready (id_ready),
        .id_out   (id_out),
        .id_valid (id_valid),
        .pending  (pending),
        .lost     (lost),
        .lost_clr (lost_clr)
    );

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_lost  = 1'b0;
    endtask

    task automatic model_edge();
        bit         accepted;
        bit [N-1:0] next_pend;
        bit         lost_event;
        int         best;
        accepted   = m_valid && id_ready;
        lost_event = 1'b0;
        best       = -1;
        for (int i = 0; i < N; i++) begin
            bit s, c;
            s = edge_sel[i] ? (irq_in[i] && !m_prev[i]) : irq_in[i];
            c = accepted && (m_id == i);
            next_pend[i] = s || (m_pend[i] && !c);
            if (edge_sel[i] && s && m_pend[i] && !c) lost_event = 1'b1;
            if (m_pend[i] && !c && mask[i]) best = i;
        end
        if (!(m_valid && !id_ready)) begin
            m_valid = en && (best >= 0);
            m_id    = (best >= 0) ? best : 0;
        end
        m_lost = lost_clr ? 1'b0 : (m_lost || lost_event);
        m_pend = next_pend;
        m_prev = irq_in;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (id_valid !== 1'b0 || pending !== 8'h00 || lost !== 1'b0 || id_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_async valid=%b pending=%h lost=%b id=%0d required 0/00/0/0",
                     id_valid, pending, lost, id_out);
        end
        repeat (3) step();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (id_valid !== 1'b0 || pending !== 8'h00 || lost !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d valid=%b pending=%h lost=%b required 0/00/0",
                         c, id_valid, pending, lost);
            end
        end
    endtask

    task automatic test_edge_pair();
        bit [3:0] exp_v [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int       exp_id[4] = '{0, 6, 3, 0};
        bit [7:0] exp_p [4] = '{8'h48, 8'h48, 8'h08, 8'h00};
        irq_in = 8'h48;
        for (int c = 0; c < 4; c++) begin
            step();
            irq_in = 8'h00;
            total++;
            if (id_valid !== exp_v[c][0] || pending !== exp_p[c] ||
                (exp_v[c][0] && id_out !== IDW'(exp_id[c]))) begin
                bad++;
                $display("FAIL edge_pair cyc=%0d valid=%b id=%0d pending=%h required %b/%0d/%h",
                         c, id_valid, id_out, pending, exp_v[c][0], exp_id[c], exp_p[c]);
            end
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        irq_in   = 8'h08;
        step();
        irq_in = 8'h00;
        step();
        irq_in = 8'h80;
        step();
        irq_in = 8'h00;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (id_valid !== 1'b1 || id_out !== 3'd3 || pending !== 8'h88) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d valid=%b id=%0d pending=%h required 1/3/88",
                         c, id_valid, id_out, pending);
            end
            step();
        end
        id_ready = 1'b1;
        step();
        total++;
        if (id_valid !== 1'b1 || id_out !== 3'd7 || pending !== 8'h80) begin
            bad++;
            $display("FAIL stall_next valid=%b id=%0d pending=%h required 1/7/80",
                     id_valid, id_out, pending);
        end
        step();
        total++;
        if (id_valid !== 1'b0 || pending !== 8'h00) begin
            bad++;
            $display("FAIL stall_drain valid=%b pending=%h required 0/00", id_valid, pending);
        end
    endtask

    task automatic test_lost();
        int grants;
        id_ready = 1'b0;
        irq_in   = 8'h04;
        step();
        irq_in = 8'h00;
        step();
        step();
        irq_in = 8'h04;
        step();
        irq_in = 8'h00;
        step();
        total++;
        if (lost !== 1'b1 || id_valid !== 1'b1 || id_out !== 3'd2) begin
            bad++;
            $display("FAIL lost_set lost=%b valid=%b id=%0d required 1/1/2", lost, id_valid, id_out);
        end
        lost_clr = 1'b1;
        step();
        lost_clr = 1'b0;
        total++;
        if (lost !== 1'b0) begin
            bad++;
            $display("FAIL lost_clear lost=%b required 0", lost);
        end
        id_ready = 1'b1;
        grants   = 0;
        for (int c = 0; c < 5; c++) begin
            if (id_valid && id_out == 3'd2) grants++;
            step();
        end
        total++;
        if (grants != 1 || pending !== 8'h00) begin
            bad++;
            $display("FAIL lost_one_grant grants=%0d pending=%h required 1/00", grants, pending);
        end
    endtask

    task automatic test_level();
        int grants;
        int wrong;
        edge_sel = 8'hDF;
        irq_in   = 8'h20;
        id_ready = 1'b1;
        grants   = 0;
        wrong    = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (id_valid) begin
                grants++;
                if (id_out !== 3'd5) wrong++;
            end
        end
        total++;
        if (grants < 3 || wrong != 0) begin
            bad++;
            $display("FAIL level_regrant grants=%0d wrong=%0d required >=3/0", grants, wrong);
        end
        mask = 8'hDF;
        step();
        step();
        for (int c = 0; c < 3; c++) begin
            total++;
            if (id_valid !== 1'b0 || pending[5] !== 1'b1) begin
                bad++;
                $display("FAIL level_masked cyc=%0d valid=%b pending=%h required 0/bit5 set",
                         c, id_valid, pending);
            end
            step();
        end
        irq_in   = 8'h00;
        edge_sel = 8'hFF;
        mask     = 8'hFF;
        repeat (5) step();
        total++;
        if (id_valid !== 1'b0 || pending !== 8'h00) begin
            bad++;
            $display("FAIL level_drain valid=%b pending=%h required 0/00", id_valid, pending);
        end
    endtask

    task automatic test_en_reset();
        en       = 1'b0;
        id_ready = 1'b1;
        irq_in   = 8'h81;
        step();
        irq_in = 8'h00;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (id_valid !== 1'b0 || pending !== 8'h81) begin
                bad++;
                $display("FAIL en_off cyc=%0d valid=%b pending=%h required 0/81", c, id_valid, pending);
            end
        end
        en = 1'b1;
        step();
        total++;
        if (id_valid !== 1'b1 || id_out !== 3'd7) begin
            bad++;
            $display("FAIL en_on valid=%b id=%0d required 1/7", id_valid, id_out);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (id_valid !== 1'b0 || id_out !== 3'd0 || pending !== 8'h00 || lost !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid valid=%b id=%0d pending=%h lost=%b required 0/0/00/0",
                     id_valid, id_out, pending, lost);
        end
        irq_in = 8'hFF;
        repeat (2) step();
        total++;
        if (id_valid !== 1'b0 || id_out !== 3'd0 || pending !== 8'h00) begin
            bad++;
            $display("FAIL rst_held valid=%b id=%0d pending=%h required 0/0/00", id_valid, id_out, pending);
        end
        irq_in = 8'h00;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 600; c++) begin
            irq_in   = N'($urandom & $urandom & $urandom);
            id_ready = ($urandom_range(0, 3) != 0);
            en       = ($urandom_range(0, 7) != 0);
            lost_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) mask = N'($urandom | $urandom);
            if ($urandom_range(0, 63) == 0) edge_sel = N'($urandom | $urandom);
            step();
            total++;
            if (pending !== m_pend || id_valid !== m_valid || lost !== m_lost ||
                (m_valid && id_out !== IDW'(m_id))) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc=%0d pending=%h valid=%b id=%0d lost=%b required %h/%b/%0d/%b",
                             c, pending, id_valid, id_out, lost, m_pend, m_valid, m_id, m_lost);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        irq_in   = '0;
        edge_sel = 8'hFF;
        mask     = 8'hFF;
        id_ready = 1'b1;
        lost_clr = 1'b0;
        model_reset();
        test_reset();
        test_edge_pair();
        test_stall();
        test_lost();
        test_level();
        test_en_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
